// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants, control bundle and immediate-format tags.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // ALU control classes handed to EX
    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    // Main control bundle produced by the decoder
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    // Which bit-scatter the immediate generator applies
    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_t;

    // Maps an opcode to its immediate layout; unknown opcodes carry no immediate.
    function automatic imm_fmt_t imm_fmt_of(input logic [6:0] opcode);
        imm_fmt_t fmt;
        fmt = IMM_NONE;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR: fmt = IMM_I;
            OP_STORE:                 fmt = IMM_S;
            OP_BRANCH:                fmt = IMM_B;
            OP_LUI, OP_AUIPC:         fmt = IMM_U;
            OP_JAL:                   fmt = IMM_J;
            default:                  fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/id_stage_top_regfile.sv
// 32x32 integer register file: two combinational read ports, one WB write port.
// Latency: reads 0 cycles; same-cycle WB data is bypassed to the read ports.
// Backpressure: none; write is accepted every cycle it is enabled.
module id_stage_top_regfile
    import riscv_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [4:0]          rs1_addr,
    input  logic [4:0]          rs2_addr,
    output logic [XLEN-1:0]     rs1_data,
    output logic [XLEN-1:0]     rs2_data,
    input  logic                wr_en,
    input  logic [4:0]          wr_addr,
    input  logic [XLEN-1:0]     wr_data
);

    logic [NREGS-1:0][XLEN-1:0] mem_q;
    logic [NREGS-1:0][XLEN-1:0] mem_d;
    logic                       wr_ok;

    // A write is live only outside reset and never targets x0; the same
    // qualifier gates the bypass so a held reset shows the cleared contents.
    assign wr_ok = reset && wr_en && (wr_addr != 5'd0);

    // Next-state of the storage: one entry replaced by WB data.
    always_comb begin
        mem_d = mem_q;
        if (wr_ok) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Storage update; reset clears every entry on each edge it is held low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    // rs1 read port: x0 hardwired, then write-through bypass, then storage.
    always_comb begin
        rs1_data = mem_q[rs1_addr];
        if (rs1_addr == 5'd0) begin
            rs1_data = '0;
        end else if (wr_ok && (wr_addr == rs1_addr)) begin
            rs1_data = wr_data;
        end
    end

    // rs2 read port: same priority as rs1, evaluated independently.
    always_comb begin
        rs2_data = mem_q[rs2_addr];
        if (rs2_addr == 5'd0) begin
            rs2_data = '0;
        end else if (wr_ok && (wr_addr == rs2_addr)) begin
            rs2_data = wr_data;
        end
    end

endmodule

// File: rtl/id_stage_top.sv
// RV32I decode stage: register read, immediate generation and main control.
// Latency: fully combinational from instr and register-file state.
// Backpressure: none; the pipeline registers around it own stalling.
module id_stage_top
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [31:0] pc_plus4,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic [31:0] imm,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic        funct7,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        alu_src,
    output logic        branch,
    output logic [1:0]  alu_op
);

    logic [6:0] opcode;
    ctrl_t      ctrl;
    imm_fmt_t   fmt;
    logic       unused_pc_plus4;

    // PC+4 is carried for a future JAL/JALR link path and has no consumer yet.
    assign unused_pc_plus4 = ^pc_plus4;

    assign opcode = instr[6:0];

    // Main control decode; anything not listed leaves every control low.
    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_R: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_R;
            end
            OP_IMM: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALUOP_I;
            end
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.alu_op     = ALUOP_ADD;
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALUOP_ADD;
            end
            OP_BRANCH: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALUOP_BR;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

    assign fmt = imm_fmt_of(opcode);

    // Immediate generation; every layout sign-extends from instr[31].
    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7],
                          instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm = {instr[31:12], 12'b0};
            IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12],
                          instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    assign reg_write  = ctrl.reg_write;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign alu_src    = ctrl.alu_src;
    assign branch     = ctrl.branch;
    assign alu_op     = ctrl.alu_op;

    // Field pass-through regardless of opcode.
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign funct7 = instr[30];

    id_stage_top_regfile u_regfile (
        .clk      (clk),
        .reset    (reset),
        .rs1_addr (instr[19:15]),
        .rs2_addr (instr[24:20]),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .wr_en    (wb_reg_write),
        .wr_addr  (wb_rd),
        .wr_data  (wb_data)
    );

endmodule

// File: tb/tb_id_stage_top.sv
module tb_id_stage_top;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        funct7;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic        branch;
    logic [1:0]  alu_op;

    int checks   = 0;
    int failures = 0;

    // Behavioural reference register file
    logic [31:0] ref_rf [32];

    always #5 clk = ~clk;

    id_stage_top dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .pc_plus4     (pc_plus4),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .imm          (imm),
        .rd           (rd),
        .funct3       (funct3),
        .funct7       (funct7),
        .reg_write    (reg_write),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_to_reg   (mem_to_reg),
        .alu_src      (alu_src),
        .branch       (branch),
        .alu_op       (alu_op)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (instr=%h)", tag, obs, exp, instr);
        end
    endtask

    // Register value an ID-stage read should see right now.
    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (reset && wb_reg_write && wb_rd == a) return wb_data;
        return ref_rf[a];
    endfunction

    // Immediate computed arithmetically from the field weights.
    function automatic logic [31:0] model_imm(input logic [31:0] i);
        logic [31:0] v;
        case (i[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                v = i[31:20];
                if (i[31]) v = v - 4096;
            end
            7'b0100011: begin
                v = i[31:25] * 32 + i[11:7];
                if (i[31]) v = v - 4096;
            end
            7'b1100011: v = i[7] * 2048 + i[30:25] * 32 + i[11:8] * 2 - i[31] * 4096;
            7'b0110111, 7'b0010111: v = (i >> 12) * 4096;
            7'b1101111: v = i[19:12] * 4096 + i[20] * 2048 + i[30:21] * 2 - i[31] * 1048576;
            default: v = 0;
        endcase
        return v;
    endfunction

    // {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, alu_op}
    function automatic logic [7:0] model_ctrl(input logic [6:0] op);
        case (op)
            7'b0110011: return 8'b1000_0010;
            7'b0010011: return 8'b1000_1011;
            7'b0000011: return 8'b1101_1000;
            7'b0100011: return 8'b0010_1000;
            7'b1100011: return 8'b0000_0101;
            default:    return 8'b0000_0000;
        endcase
    endfunction

    // Compare every output against the model.
    task automatic check_all(input string tag);
        check_eq({tag, ".rs1"}, rs1_data, model_read(instr[19:15]));
        check_eq({tag, ".rs2"}, rs2_data, model_read(instr[24:20]));
        check_eq({tag, ".imm"}, imm, model_imm(instr));
        check_eq({tag, ".ctrl"},
                 {24'd0, reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, alu_op},
                 {24'd0, model_ctrl(instr[6:0])});
        check_eq({tag, ".fields"}, {23'd0, rd, funct3, funct7},
                 {23'd0, instr[11:7], instr[14:12], instr[30]});
    endtask

    // Advance one edge and apply the same edge to the model; inputs change #1 later.
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            for (int k = 0; k < 32; k++) ref_rf[k] = 32'd0;
        end else if (wb_reg_write && wb_rd != 0) begin
            ref_rf[wb_rd] = wb_data;
        end
        #1;
    endtask

    logic [6:0] ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                             7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111};

    initial begin
        logic [31:0] r;
        for (int k = 0; k < 32; k++) ref_rf[k] = 32'd0;
        reset        = 1'b0;
        instr        = 32'h0000_0000;
        pc_plus4     = 32'd4;
        wb_reg_write = 1'b0;
        wb_rd        = 5'd0;
        wb_data      = 32'd0;

        // Reset state after one held edge
        tick();
        instr = 32'h0020_8000;   // rs1=1, rs2=2, opcode 0
        #1;
        check_eq("rst.rs1", rs1_data, 32'd0);
        check_eq("rst.rs2", rs2_data, 32'd0);
        check_eq("rst.imm", imm, 32'd0);
        check_eq("rst.ctrl", {30'd0, reg_write, alu_src}, 32'd0);
        reset = 1'b1;

        // Write x1=10, then addi x2,x1,5
        wb_reg_write = 1'b1; wb_rd = 5'd1; wb_data = 32'd10;
        tick();
        wb_reg_write = 1'b0;
        instr = 32'h0050_8113;
        #1;
        check_eq("addi.rs1", rs1_data, 32'd10);
        check_eq("addi.imm", imm, 32'd5);
        check_eq("addi.rd", {27'd0, rd}, 32'd2);
        check_eq("addi.ctl", {27'd0, reg_write, alu_src, mem_read, mem_write, branch}, 32'b11000);
        check_eq("addi.aluop", {30'd0, alu_op}, 32'd3);
        check_all("addi");

        // x0 protection
        wb_reg_write = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD_BEEF;
        instr = 32'h0000_0013;
        #1;
        check_eq("x0.byp", rs1_data, 32'd0);
        tick();
        wb_reg_write = 1'b0;
        #1;
        check_eq("x0.rs1", rs1_data, 32'd0);

        // Same-cycle write-through bypass on rs2
        instr = 32'h0030_0233;   // add x4,x0,x3
        wb_reg_write = 1'b1; wb_rd = 5'd3; wb_data = 32'h55;
        #1;
        check_eq("byp.rs2", rs2_data, 32'h55);
        tick();
        wb_reg_write = 1'b0;
        #1;
        check_eq("byp.held", rs2_data, 32'h55);

        // Store decode
        instr = 32'hFE30_AE23;
        #1;
        check_eq("sw.imm", imm, 32'hFFFF_FFFC);
        check_eq("sw.ctl", {29'd0, mem_write, alu_src, reg_write}, 32'b110);
        check_eq("sw.aluop", {30'd0, alu_op}, 32'd0);
        check_all("sw");

        // Branch decode
        instr = 32'hFE20_8CE3;
        #1;
        check_eq("beq.imm", imm, 32'hFFFF_FFF8);
        check_eq("beq.br", {30'd0, branch, reg_write}, 32'b10);
        check_eq("beq.aluop", {30'd0, alu_op}, 32'd1);
        check_eq("beq.f3", {29'd0, funct3}, 32'd0);

        // Reset clears x1; bypass disabled while reset is low
        instr = 32'h0000_8013;   // addi x0,x1,0
        reset = 1'b0;
        wb_reg_write = 1'b1; wb_rd = 5'd1; wb_data = 32'h1234;
        #1;
        check_eq("rstlo.rs1", rs1_data, 32'd10);
        tick();
        reset = 1'b1; wb_reg_write = 1'b0;
        #1;
        check_eq("rstclr.rs1", rs1_data, 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            r = $urandom();
            instr = {r[31:25], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     r[14:7], ops[$urandom_range(0, 9)]};
            if ($urandom_range(0, 9) == 0) instr[6:0] = 7'($urandom());
            pc_plus4     = $urandom();
            wb_reg_write = 1'($urandom_range(0, 1));
            wb_rd        = 5'($urandom_range(0, 7));
            wb_data      = $urandom();
            reset        = ($urandom_range(0, 24) != 0);
            #1;
            check_all("rnd");
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
